module_top: RTL and testbench

MODULE_TOP -- requirements
Module: module_top

---
 rtl/module_top.sv | 120 ++++++++++++
 tb/tb_module_top.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/module_top.sv
// Serial-to-parallel receiver feeding an 8-deep, 8-bit word FIFO.
// Bits arrive on rising edges of write_in and are assembled LSB-first by
// default. Defining MSB_FIRST_EN makes the first received bit land in bit 7.
// Words are popped on rising edges of dequeue_in into data_out.
//
// Handshake: write_in and dequeue_in are level strobes and only their 0->1
// transitions (detected against a registered copy) act. A bit is taken only
// while status_out=1 (queue not full). A pop is taken only when the queue is
// non-empty. A finished word is pushed one clock after its 8th bit.
module module_top (
  input  logic       clock,
  input  logic       reset,
  input  logic       data_in,
  input  logic       write_in,
  input  logic       dequeue_in,
  output logic       status_out,
  output logic [3:0] len_out,
  output logic [7:0] data_out
);

  logic       wr_prev_q, wr_prev_d;
  logic       deq_prev_q, deq_prev_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       push_pend_q, push_pend_d;
  logic [2:0] wptr_q, wptr_d;
  logic [2:0] rptr_q, rptr_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] dout_q, dout_d;
  logic [7:0] mem_q [8];

  logic strobe;
  logic accept;
  logic push;
  logic pop;

  assign status_out = (cnt_q != 4'd8);
  assign len_out    = cnt_q;
  assign data_out   = dout_q;

  assign strobe = write_in & ~wr_prev_q;
  assign accept = strobe & status_out;
  assign push   = push_pend_q;
  // Pop on an empty queue is dropped, even if a push lands on the same edge.
  assign pop    = dequeue_in & ~deq_prev_q & (cnt_q != 4'd0);

  // Next-state logic for deserializer, pointers, count and output word.
  always_comb begin
    wr_prev_d   = write_in;
    deq_prev_d  = dequeue_in;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    push_pend_d = 1'b0;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    cnt_d       = cnt_q;
    dout_d      = dout_q;

    if (accept) begin
`ifdef MSB_FIRST_EN
      shift_d = {shift_q[6:0], data_in};
`else
      shift_d = {data_in, shift_q[7:1]};
`endif
      // 3-bit counter wraps 7->0 on the 8th bit.
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        push_pend_d = 1'b1;
      end
    end

    if (push) begin
      wptr_d = wptr_q + 3'd1;
    end

    if (pop) begin
      dout_d = mem_q[rptr_q];
      rptr_d = rptr_q + 3'd1;
    end

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 4'd1;
      2'b01:   cnt_d = cnt_q - 4'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Control and datapath registers, cleared by the asynchronous reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_prev_q   <= 1'b0;
      deq_prev_q  <= 1'b0;
      shift_q     <= 8'h00;
      bit_cnt_q   <= 3'd0;
      push_pend_q <= 1'b0;
      wptr_q      <= 3'd0;
      rptr_q      <= 3'd0;
      cnt_q       <= 4'd0;
      dout_q      <= 8'h00;
    end else begin
      wr_prev_q   <= wr_prev_d;
      deq_prev_q  <= deq_prev_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      push_pend_q <= push_pend_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      cnt_q       <= cnt_d;
      dout_q      <= dout_d;
    end
  end

  // Queue storage; contents are don't-care until written since count gates reads.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wptr_q] <= shift_q;
    end
  end

endmodule

// File: tb/tb_module_top.sv
// Bench for module_top: directed table, hand-written corner sequences and a
// randomized run against a queue-based reference model.
module tb_module_top;

  logic       clock;
  logic       reset;
  logic       data_in;
  logic       write_in;
  logic       dequeue_in;
  logic       status_out;
  logic [3:0] len_out;
  logic [7:0] data_out;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [7:0] mq[$];
  logic       mbits[$];
  logic [7:0] mdata;

  typedef struct {
    int         op;    // 0 = send word, 1 = pop
    logic [7:0] arg;
    int         hi;
    int         lo;
    logic [3:0] e_len;
    logic [7:0] e_data;
    logic       e_st;
  } vec_t;

  vec_t tbl[$];

  module_top dut (
    .clock      (clock),
    .reset      (reset),
    .data_in    (data_in),
    .write_in   (write_in),
    .dequeue_in (dequeue_in),
    .status_out (status_out),
    .len_out    (len_out),
    .data_out   (data_out)
  );

  // Clock generation.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [3:0] e_len,
                            input logic [7:0] e_data, input logic e_st);
    check({tag, ".len"}, {4'd0, len_out}, {4'd0, e_len});
    check({tag, ".data"}, data_out, e_data);
    check({tag, ".status"}, {7'd0, status_out}, {7'd0, e_st});
  endtask

  // Transmission order of bit i of a word.
  function automatic logic bit_of(input logic [7:0] w, input int i);
`ifdef MSB_FIRST_EN
    return w[7-i];
`else
    return w[i];
`endif
  endfunction

  function automatic void model_reset();
    mq.delete();
    mbits.delete();
    mdata = 8'h00;
  endfunction

  function automatic void model_bit(input logic b);
    logic [7:0] w;
    if (mq.size() < 8) begin
      mbits.push_back(b);
      if (mbits.size() == 8) begin
        for (int i = 0; i < 8; i++) begin
`ifdef MSB_FIRST_EN
          w[7-i] = mbits[i];
`else
          w[i] = mbits[i];
`endif
        end
        mq.push_back(w);
        mbits.delete();
      end
    end
  endfunction

  function automatic void model_pop();
    if (mq.size() > 0) mdata = mq.pop_front();
  endfunction

  task automatic send_bit(input logic b, input int hi, input int lo);
    data_in  = b;
    write_in = 1'b1;
    repeat (hi) tick();
    write_in = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic send_word(input logic [7:0] w, input int hi, input int lo);
    for (int i = 0; i < 8; i++) send_bit(bit_of(w, i), hi, lo);
  endtask

  task automatic pop_pulse(input int hi, input int lo);
    dequeue_in = 1'b1;
    repeat (hi) tick();
    dequeue_in = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic do_reset(input string tag);
    write_in   = 1'b0;
    dequeue_in = 1'b0;
    reset      = 1'b0;
    tick();
    check_outs(tag, 4'd0, 8'h00, 1'b1);
    tick();
    reset = 1'b1;
    tick();
    model_reset();
  endtask

  function automatic void add(input int op, input logic [7:0] arg, input int hi, input int lo,
                              input logic [3:0] e_len, input logic [7:0] e_data, input logic e_st);
    vec_t v;
    v.op = op; v.arg = arg; v.hi = hi; v.lo = lo;
    v.e_len = e_len; v.e_data = e_data; v.e_st = e_st;
    tbl.push_back(v);
  endfunction

  initial begin
    logic [7:0] w;
    logic       b;
    int         n;

    reset      = 1'b0;
    data_in    = 1'b0;
    write_in   = 1'b0;
    dequeue_in = 1'b0;
    model_reset();
    tick();
    tick();
    check_outs("reset", 4'd0, 8'h00, 1'b1);
    reset = 1'b1;
    tick();

    // Directed table: fill, hold-pop, drain, full queue, ignored bits, wrap drain.
    add(0, 8'h99, 10, 10, 4'd1, 8'h00, 1'b1);
    add(0, 8'hF0, 10, 10, 4'd2, 8'h00, 1'b1);
    add(0, 8'h0F, 10, 10, 4'd3, 8'h00, 1'b1);
    add(0, 8'hAA, 10, 10, 4'd4, 8'h00, 1'b1);
    add(1, 8'h00, 200, 2, 4'd3, 8'h99, 1'b1);
    add(1, 8'h00, 3, 2, 4'd2, 8'hF0, 1'b1);
    add(1, 8'h00, 1, 1, 4'd1, 8'h0F, 1'b1);
    add(1, 8'h00, 1, 1, 4'd0, 8'hAA, 1'b1);
    add(1, 8'h00, 2, 2, 4'd0, 8'hAA, 1'b1);
    for (int i = 1; i <= 8; i++)
      add(0, 8'(i), 1 + (i % 3), 1 + (i % 2), 4'(i), 8'hAA, (i < 8));
    add(0, 8'hFF, 2, 1, 4'd8, 8'hAA, 1'b0);
    for (int i = 1; i <= 8; i++)
      add(1, 8'h00, 1 + (i % 2), 1, 4'(8 - i), 8'(i), 1'b1);

    foreach (tbl[k]) begin
      if (tbl[k].op == 0) send_word(tbl[k].arg, tbl[k].hi, tbl[k].lo);
      else                pop_pulse(tbl[k].hi, tbl[k].lo);
      check_outs($sformatf("tbl%0d", k), tbl[k].e_len, tbl[k].e_data, tbl[k].e_st);
    end

    // Pop on an empty queue right after reset.
    do_reset("rst_a");
    pop_pulse(2, 2);
    check_outs("empty_pop", 4'd0, 8'h00, 1'b1);

    // Push of a finished word coinciding with a pop edge.
    send_word(8'h11, 1, 1);
    send_word(8'h22, 1, 1);
    check_outs("coin_pre", 4'd2, 8'h00, 1'b1);
    for (int i = 0; i < 7; i++) send_bit(bit_of(8'h5A, i), 1, 1);
    data_in  = bit_of(8'h5A, 7);
    write_in = 1'b1;
    tick();
    check_outs("push_latency", 4'd2, 8'h00, 1'b1);
    write_in   = 1'b0;
    dequeue_in = 1'b1;
    tick();
    check_outs("coin", 4'd2, 8'h11, 1'b1);
    dequeue_in = 1'b0;
    tick();
    pop_pulse(1, 1);
    check_outs("coin_p1", 4'd1, 8'h22, 1'b1);
    pop_pulse(1, 1);
    check_outs("coin_p2", 4'd0, 8'h5A, 1'b1);

    // Partial word and queued data discarded by reset.
    send_word(8'h77, 1, 1);
    for (int i = 0; i < 5; i++) send_bit(i[0], 1, 1);
    do_reset("rst_b");
    check_outs("rst_b_after", 4'd0, 8'h00, 1'b1);
    send_word(8'h3C, 2, 2);
    check_outs("post_rst", 4'd1, 8'h00, 1'b1);
    pop_pulse(2, 2);
    check_outs("post_rst_pop", 4'd0, 8'h3C, 1'b1);

    // Randomized traffic against the reference model.
    do_reset("rst_c");
    for (int k = 0; k < 300; k++) begin
      case ($urandom_range(0, 3))
        0, 1: begin
          w = 8'($urandom);
          for (int i = 0; i < 8; i++) begin
            b = bit_of(w, i);
            send_bit(b, $urandom_range(1, 3), $urandom_range(1, 3));
            model_bit(b);
          end
        end
        2: begin
          n = $urandom_range(1, 3);
          for (int i = 0; i < n; i++) begin
            b = 1'($urandom);
            send_bit(b, $urandom_range(1, 3), $urandom_range(1, 3));
            model_bit(b);
          end
        end
        default: begin
          pop_pulse($urandom_range(1, 4), $urandom_range(1, 3));
          model_pop();
        end
      endcase
      check_outs($sformatf("rnd%0d", k), 4'(mq.size()), mdata, (mq.size() < 8));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
